// File: rtl/eth_rx_frame_filter.sv
// Store-and-forward RX buffer: commits only clean frames and replays them gap-free.
// Optional destination MAC filter is enabled by defining ETH_RX_DST_MAC_FILTER_EN.
module eth_rx_frame_filter #(
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rx_axis_aclk,
    input  logic                  rx_axis_areset,
    input  logic [63:0]           s_axis_tdata,
    input  logic [7:0]            s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [63:0]           m_axis_tdata,
    output logic [7:0]            m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic [47:0]           local_mac_addr,
    output logic [ADDR_WIDTH:0]   frames_stored,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [CNT_WIDTH-1:0]  pass_cnt
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {WR_IDLE, WR_STORE, WR_DROP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [ADDR_WIDTH-1:0] wr_ptr, commit_ptr, rd_ptr, wr_ptr_inc;
    logic [72:0]           mem [DEPTH];
    logic [DEPTH-1:0]      last_bits;
    logic [72:0]           rd_q;
    logic                  m_vld;
    logic                  full, dst_ok;
    logic                  do_write, do_commit, do_drop;
    logic                  rd_issue, rd_last;

    assign wr_ptr_inc = wr_ptr + ADDR_WIDTH'(1);
    assign full       = (wr_ptr_inc == rd_ptr);

`ifdef ETH_RX_DST_MAC_FILTER_EN
    // Wire byte 0 sits in tdata[7:0], so the local address is byte-reversed.
    logic [47:0] local_wire;
    assign local_wire = {local_mac_addr[7:0],   local_mac_addr[15:8],
                         local_mac_addr[23:16], local_mac_addr[31:24],
                         local_mac_addr[39:32], local_mac_addr[47:40]};
    assign dst_ok = (s_axis_tdata[47:0] == local_wire) ||
                    (s_axis_tdata[47:0] == {48{1'b1}});
`else
    logic unused_mac;
    assign unused_mac = ^local_mac_addr;
    assign dst_ok     = 1'b1;
`endif

    always_comb begin
        wr_next   = wr_state;
        do_write  = 1'b0;
        do_commit = 1'b0;
        do_drop   = 1'b0;
        if (s_axis_tvalid) begin
            case (wr_state)
                WR_IDLE, WR_STORE: begin
                    if (full || (wr_state == WR_IDLE && !dst_ok)) begin
                        do_drop = s_axis_tlast;
                        wr_next = s_axis_tlast ? WR_IDLE : WR_DROP;
                    end else begin
                        do_write = 1'b1;
                        if (s_axis_tlast) begin
                            wr_next   = WR_IDLE;
                            do_drop   = s_axis_tuser;
                            do_commit = !s_axis_tuser;
                        end else begin
                            wr_next = WR_STORE;
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis_tlast) begin
                        do_drop = 1'b1;
                        wr_next = WR_IDLE;
                    end
                end
                default: wr_next = WR_IDLE;
            endcase
        end
    end

    // tlast is mirrored in flops so the reader knows at issue time where a frame ends.
    always_comb begin
        rd_next  = rd_state;
        rd_issue = 1'b0;
        case (rd_state)
            RD_IDLE: if (frames_stored != '0) rd_next = RD_RUN;
            RD_RUN: begin
                rd_issue = 1'b1;
                if (last_bits[rd_ptr]) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end
    assign rd_last = rd_issue && last_bits[rd_ptr];

    always_ff @(posedge rx_axis_aclk) begin
        if (do_write) begin
            mem[wr_ptr]       <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
            last_bits[wr_ptr] <= s_axis_tlast;
        end
        if (rd_issue) rd_q <= mem[rd_ptr];
    end

    always_ff @(posedge rx_axis_aclk or posedge rx_axis_areset) begin
        if (rx_axis_areset) begin
            wr_state      <= WR_IDLE;
            rd_state      <= RD_IDLE;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            rd_ptr        <= '0;
            frames_stored <= '0;
            drop_cnt      <= '0;
            pass_cnt      <= '0;
            m_vld         <= 1'b0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            m_vld    <= rd_issue;
            if (do_drop)       wr_ptr <= commit_ptr;
            else if (do_write) wr_ptr <= wr_ptr_inc;
            if (do_commit) commit_ptr <= wr_ptr_inc;
            if (rd_issue)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({do_commit, rd_last})
                2'b10:   frames_stored <= frames_stored + (ADDR_WIDTH+1)'(1);
                2'b01:   frames_stored <= frames_stored - (ADDR_WIDTH+1)'(1);
                default: frames_stored <= frames_stored;
            endcase
            if (do_commit && pass_cnt != '1) pass_cnt <= pass_cnt + CNT_WIDTH'(1);
            if (do_drop && drop_cnt != '1)   drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
    end

    // Data is gated so every output reads 0 whenever nothing is being replayed.
    assign m_axis_tvalid = m_vld;
    assign m_axis_tdata  = m_vld ? rd_q[63:0]  : '0;
    assign m_axis_tkeep  = m_vld ? rd_q[71:64] : '0;
    assign m_axis_tlast  = m_vld & rd_q[72];
    assign m_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Directed bench for eth_rx_frame_filter with a 16-beat buffer; outputs captured on negedge.
module tb_eth_rx_frame_filter;
    localparam int AW = 4;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic        clk, rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tlast, s_tuser;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tlast, m_tuser;
    logic [47:0] local_mac;
    logic [AW:0] frames_stored;
    logic [15:0] drop_cnt, pass_cnt;

    eth_rx_frame_filter #(.ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
        .rx_axis_aclk(clk), .rx_axis_areset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .local_mac_addr(local_mac), .frames_stored(frames_stored),
        .drop_cnt(drop_cnt), .pass_cnt(pass_cnt)
    );

    int n_cmp = 0, n_err = 0;
    int cyc = 0, tl_cyc = 0;
    int peak = 0;
    logic [73:0] q_dat[$];
    int          q_cyc[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_tvalid) begin
            q_dat.push_back({m_tuser, m_tlast, m_tkeep, m_tdata});
            q_cyc.push_back(cyc);
        end
        if (int'(frames_stored) > peak) peak = int'(frames_stored);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Upper 16 bits step per beat; the low 48 bits (dst MAC on beat 0) stay fixed.
    function automatic logic [63:0] beat_data(input logic [63:0] d0, input int i);
        return {d0[63:48] + 16'(i), d0[47:0]};
    endfunction

    task automatic send(input int n, input logic [63:0] d0, input logic [7:0] lk, input logic tu);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            s_tvalid = 1'b1;
            s_tdata  = beat_data(d0, i);
            s_tkeep  = (i == n - 1) ? lk : 8'hFF;
            s_tlast  = (i == n - 1);
            s_tuser  = (i == n - 1) ? tu : 1'b0;
            if (i == n - 1) tl_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_frame(input string tag, input int base, input int n,
                             input logic [63:0] d0, input logic [7:0] lk);
        for (int i = 0; i < n; i++) begin
            if (base + i < q_dat.size())
                chk(tag, q_dat[base + i],
                    {1'b0, (i == n - 1), ((i == n - 1) ? lk : 8'hFF), beat_data(d0, i)});
        end
    endtask

    initial begin
        rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tvalid = 0; s_tlast = 0; s_tuser = 0;
        local_mac = 48'h000A35010203;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tkeep", m_tkeep, 0);
        chk("rst_fs", frames_stored, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_pass", pass_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(3);

        // good 8-beat frame
        q_dat.delete(); q_cyc.delete();
        send(8, {16'hA100, BCAST}, 8'hFF, 1'b0);
        idle(20);
        chk("good_len", q_dat.size(), 8);
        chk_frame("good_beat", 0, 8, {16'hA100, BCAST}, 8'hFF);
        if (q_cyc.size() > 0) chk("good_lat", q_cyc[0] - tl_cyc, 3);
        chk("good_pass", pass_cnt, 1);
        chk("good_fs", frames_stored, 0);

        // errored frame followed by a good 3-beat frame
        q_dat.delete(); q_cyc.delete();
        send(10, {16'hB100, BCAST}, 8'hFF, 1'b1);
        send(3, {16'hB200, BCAST}, 8'h0F, 1'b0);
        idle(25);
        chk("err_len", q_dat.size(), 3);
        chk_frame("err_beat", 0, 3, {16'hB200, BCAST}, 8'h0F);
        chk("err_drop", drop_cnt, 1);
        chk("err_pass", pass_cnt, 2);

        // overflow: 20-beat frame can never fit while an 8-beat frame replays
        q_dat.delete(); q_cyc.delete();
        send(8, {16'hC100, BCAST}, 8'hFF, 1'b0);
        send(20, {16'hC200, BCAST}, 8'hFF, 1'b0);
        idle(30);
        chk("ovf_wrptr", dut.wr_ptr, 3);
        chk("ovf_drop", drop_cnt, 2);
        chk("ovf_pass", pass_cnt, 3);
        send(4, {16'hC300, BCAST}, 8'h01, 1'b0);
        idle(20);
        chk("ovf_len", q_dat.size(), 12);
        chk_frame("ovf_a", 0, 8, {16'hC100, BCAST}, 8'hFF);
        chk_frame("ovf_c", 8, 4, {16'hC300, BCAST}, 8'h01);
        chk("ovf_pass2", pass_cnt, 4);
        chk("ovf_fs", frames_stored, 0);

        // three back-to-back 2-beat frames
        q_dat.delete(); q_cyc.delete(); peak = 0;
        send(2, {16'hD100, BCAST}, 8'h03, 1'b0);
        send(2, {16'hD200, BCAST}, 8'h07, 1'b0);
        send(2, {16'hD300, BCAST}, 8'hFF, 1'b0);
        idle(25);
        chk("b2b_len", q_dat.size(), 6);
        chk_frame("b2b_f1", 0, 2, {16'hD100, BCAST}, 8'h03);
        chk_frame("b2b_f2", 2, 2, {16'hD200, BCAST}, 8'h07);
        chk_frame("b2b_f3", 4, 2, {16'hD300, BCAST}, 8'hFF);
        if (q_cyc.size() == 6) begin
            chk("b2b_in", q_cyc[1] - q_cyc[0], 1);
            chk("b2b_gap1", q_cyc[2] - q_cyc[1], 2);
            chk("b2b_gap2", q_cyc[4] - q_cyc[3], 2);
        end
        chk("b2b_peak", peak >= 1, 1);
        chk("b2b_fs", frames_stored, 0);
        chk("b2b_pass", pass_cnt, 7);
        chk("b2b_drop", drop_cnt, 2);

        // reset during beat 3 of a 6-beat frame
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            s_tvalid = 1'b1; s_tdata = beat_data({16'hE100, BCAST}, i);
            s_tkeep = 8'hFF; s_tlast = 1'b0;
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_tvalid", m_tvalid, 0);
        chk("mid_tdata", m_tdata, 0);
        chk("mid_fs", frames_stored, 0);
        chk("mid_pass", pass_cnt, 0);
        chk("mid_drop", drop_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);
        q_dat.delete(); q_cyc.delete();
        send(1, {16'hE200, BCAST}, 8'h3F, 1'b0);
        idle(15);
        chk("rst_len", q_dat.size(), 1);
        chk_frame("rst_beat", 0, 1, {16'hE200, BCAST}, 8'h3F);
        if (q_cyc.size() > 0) chk("rst_lat", q_cyc[0] - tl_cyc, 3);
        chk("rst_pass", pass_cnt, 1);

        // destination MAC: mismatch, broadcast, local
        q_dat.delete(); q_cyc.delete();
        send(2, {16'hF100, 48'h040201350A00}, 8'hFF, 1'b0);
        send(2, {16'hF200, BCAST}, 8'hFF, 1'b0);
        send(2, {16'hF300, 48'h030201350A00}, 8'h0F, 1'b0);
        idle(25);
`ifdef ETH_RX_DST_MAC_FILTER_EN
        chk("flt_len", q_dat.size(), 4);
        chk_frame("flt_bc", 0, 2, {16'hF200, BCAST}, 8'hFF);
        chk_frame("flt_loc", 2, 2, {16'hF300, 48'h030201350A00}, 8'h0F);
        chk("flt_drop", drop_cnt, 1);
        chk("flt_pass", pass_cnt, 3);
`else
        chk("nof_len", q_dat.size(), 6);
        chk_frame("nof_other", 0, 2, {16'hF100, 48'h040201350A00}, 8'hFF);
        chk_frame("nof_loc", 4, 2, {16'hF300, 48'h030201350A00}, 8'h0F);
        chk("nof_drop", drop_cnt, 0);
        chk("nof_pass", pass_cnt, 4);
`endif
        chk("end_fs", frames_stored, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
